// File: rtl/mem_responder.sv
// Memory-side responder for the CPU rd/wr/datactl_ena bus.
// Decodes the address into ROM, RAM and one I/O register. Read data is returned
// one edge after rd is sampled. Each wr pulse commits exactly one write.
// Protocol and decode errors are kept as sticky flags.
module mem_responder #(
   parameter int              AW        = 13,
   parameter int              DW        = 8,
   parameter int              ROM_DEPTH = 256,
   parameter logic [AW-1:0]   RAM_BASE  = 13'h1800,
   parameter int              RAM_DEPTH = 256,
   parameter logic [AW-1:0]   IO_ADDR   = 13'h1F00
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] i_addr,
   input  logic          i_rd,
   input  logic          i_wr,
   input  logic          i_datactl_ena,
   input  logic [DW-1:0] i_wdata,
   output logic [DW-1:0] o_rdata,
   output logic          o_rdata_oe,
   input  logic [DW-1:0] i_io_in,
   output logic [DW-1:0] o_io_out,
   input  logic          i_prog_we,
   input  logic [AW-1:0] i_prog_addr,
   input  logic [DW-1:0] i_prog_data,
   output logic [2:0]    o_err,
   input  logic          i_err_clr
);

   localparam int ROM_IW = $clog2(ROM_DEPTH);
   localparam int RAM_IW = $clog2(RAM_DEPTH);
   // One extra bit keeps the range limits from overflowing the address width
   localparam logic [AW:0] LP_ROM_END = (AW+1)'(ROM_DEPTH);
   localparam logic [AW:0] LP_RAM_LO  = {1'b0, RAM_BASE};
   localparam logic [AW:0] LP_RAM_HI  = LP_RAM_LO + (AW+1)'(RAM_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

   state_t r_state, w_state_nxt;

   logic [DW-1:0] r_rom [ROM_DEPTH];
   logic [DW-1:0] r_ram [RAM_DEPTH];

   logic [DW-1:0] r_rdata;
   logic          r_rdata_oe;
   logic [DW-1:0] r_io_out;
   logic [2:0]    r_err;

   logic [AW:0]     w_addr_x;
   logic            w_is_rom, w_is_io, w_is_ram, w_mapped;
   logic [ROM_IW-1:0] w_rom_idx, w_prog_idx;
   logic [RAM_IW-1:0] w_ram_idx;
   logic            w_prog_ok;
   logic [DW-1:0]   w_rd_word;
   logic            w_do_read, w_do_write, w_coll;
   logic            w_ram_we, w_io_we, w_illegal_wr, w_unmapped_rd;
   logic [2:0]      w_err_set;

   // Address decode and read-data selection
   always_comb begin
      w_addr_x   = {1'b0, i_addr};
      w_is_rom   = (w_addr_x < LP_ROM_END);
      w_is_io    = (i_addr == IO_ADDR);
      w_is_ram   = (w_addr_x >= LP_RAM_LO) && (w_addr_x < LP_RAM_HI);
      w_mapped   = w_is_rom | w_is_io | w_is_ram;
      w_rom_idx  = ROM_IW'(i_addr);
      w_ram_idx  = RAM_IW'(i_addr - RAM_BASE);
      w_prog_idx = ROM_IW'(i_prog_addr);
      w_prog_ok  = ({1'b0, i_prog_addr} < LP_ROM_END);
      w_rd_word  = '0;
      if (w_is_rom)      w_rd_word = r_rom[w_rom_idx];
      else if (w_is_io)  w_rd_word = i_io_in;
      else if (w_is_ram) w_rd_word = r_ram[w_ram_idx];
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_rd && !i_wr)      w_state_nxt = S_RD;
            else if (i_wr && !i_rd) w_state_nxt = S_WR;
            else                    w_state_nxt = S_IDLE;
         end
         S_RD: begin
            if (i_rd && !i_wr)      w_state_nxt = S_RD;
            else if (i_wr && !i_rd) w_state_nxt = S_WR;   // read ended, write starts same edge
            else                    w_state_nxt = S_IDLE;
         end
         S_WR: begin
            if (i_wr && !i_rd)      w_state_nxt = S_WR;
            else                    w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM action decode: which access (if any) happens on this edge
   always_comb begin
      w_do_read  = 1'b0;
      w_do_write = 1'b0;
      w_coll     = 1'b0;
      if (!rst) begin
         case (r_state)
            S_IDLE, S_RD: begin
               w_do_read  = i_rd & ~i_wr;
               w_do_write = i_wr & ~i_rd;
               w_coll     = i_rd & i_wr;
            end
            S_WR: begin
               // Held wr never writes again; only a collision is reported
               w_coll = i_rd & i_wr;
            end
            default: ;
         endcase
      end
   end

   // Write commit and error source qualification
   always_comb begin
      w_ram_we      = w_do_write & i_datactl_ena & w_is_ram;
      w_io_we       = w_do_write & i_datactl_ena & w_is_io;
      w_illegal_wr  = w_do_write & ~(w_ram_we | w_io_we);
      w_unmapped_rd = w_do_read & ~w_mapped;
      w_err_set     = {w_unmapped_rd, w_illegal_wr, w_coll};
   end

   // Read data, output enable, I/O register and sticky errors
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata    <= '0;
         r_rdata_oe <= 1'b0;
         r_io_out   <= '0;
         r_err      <= '0;
      end else begin
         r_rdata_oe <= w_do_read;
         if (w_do_read) r_rdata  <= w_rd_word;
         if (w_io_we)   r_io_out <= i_wdata;
         r_err <= (i_err_clr ? 3'b000 : r_err) | w_err_set;
      end
   end

   // Storage arrays; contents survive reset, preload runs in any state
   always_ff @(posedge clk) begin
      if (w_ram_we)               r_ram[w_ram_idx]  <= i_wdata;
      if (i_prog_we && w_prog_ok) r_rom[w_prog_idx] <= i_prog_data;
   end

   assign o_rdata    = r_rdata;
   assign o_rdata_oe = r_rdata_oe;
   assign o_io_out   = r_io_out;
   assign o_err      = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: expected read words are queued when a read is driven
// and compared whenever the responder presents rdata with rdata_oe.
module tb_mem_responder;

   localparam int AW = 13;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] i_addr;
   logic          i_rd, i_wr, i_datactl_ena;
   logic [DW-1:0] i_wdata;
   logic [DW-1:0] o_rdata;
   logic          o_rdata_oe;
   logic [DW-1:0] i_io_in;
   logic [DW-1:0] o_io_out;
   logic          i_prog_we;
   logic [AW-1:0] i_prog_addr;
   logic [DW-1:0] i_prog_data;
   logic [2:0]    o_err;
   logic          i_err_clr;

   int n_checks = 0;
   int n_errors = 0;
   logic [DW-1:0] exp_q [$];

   mem_responder dut (
      .clk          (clk),
      .rst          (rst),
      .i_addr       (i_addr),
      .i_rd         (i_rd),
      .i_wr         (i_wr),
      .i_datactl_ena(i_datactl_ena),
      .i_wdata      (i_wdata),
      .o_rdata      (o_rdata),
      .o_rdata_oe   (o_rdata_oe),
      .i_io_in      (i_io_in),
      .o_io_out     (o_io_out),
      .i_prog_we    (i_prog_we),
      .i_prog_addr  (i_prog_addr),
      .i_prog_data  (i_prog_data),
      .o_err        (o_err),
      .i_err_clr    (i_err_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every presented read word must match the oldest queued expectation
   always @(negedge clk) begin
      if (o_rdata_oe) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_oe", 32'(o_rdata), 32'hDEAD);
         end else begin
            check("sb_rdata", 32'(o_rdata), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      rst = 1'b1; i_addr = '0; i_rd = 1'b0; i_wr = 1'b0; i_datactl_ena = 1'b0;
      i_wdata = '0; i_io_in = '0; i_prog_we = 1'b0; i_prog_addr = '0;
      i_prog_data = '0; i_err_clr = 1'b0;

      // Reset for two edges
      tick(); tick();
      check("rst_rdata", 32'(o_rdata), 0);
      check("rst_oe",    32'(o_rdata_oe), 0);
      check("rst_io",    32'(o_io_out), 0);
      check("rst_err",   32'(o_err), 0);
      rst = 1'b0;

      // Preload ROM[5] = 3C
      i_prog_we = 1'b1; i_prog_addr = 13'd5; i_prog_data = 8'h3C;
      tick();
      i_prog_we = 1'b0;

      // Two-cycle read of ROM[5]
      i_addr = 13'd5; i_rd = 1'b1; exp_q.push_back(8'h3C);
      tick();
      check("rom_rd_oe1", 32'(o_rdata_oe), 1);
      exp_q.push_back(8'h3C);
      tick();
      i_rd = 1'b0;
      tick();
      check("rom_rd_oe_drop", 32'(o_rdata_oe), 0);
      check("rdata_hold", 32'(o_rdata), 32'h3C);

      // wr held 3 cycles, only the first word must land
      i_addr = 13'h1810; i_wr = 1'b1; i_datactl_ena = 1'b1; i_wdata = 8'hA5;
      tick();
      i_wdata = 8'h11; tick();
      i_wdata = 8'h22; tick();
      i_wr = 1'b0; i_datactl_ena = 1'b0;
      tick();
      i_rd = 1'b1; exp_q.push_back(8'hA5);
      tick();
      i_rd = 1'b0;
      tick();
      check("ram_wr_err", 32'(o_err), 0);

      // I/O register write and read
      i_addr = 13'h1F00; i_wr = 1'b1; i_datactl_ena = 1'b1; i_wdata = 8'h7E;
      tick();
      i_wr = 1'b0; i_datactl_ena = 1'b0;
      check("io_out", 32'(o_io_out), 32'h7E);
      tick();
      i_io_in = 8'h42; i_rd = 1'b1; exp_q.push_back(8'h42);
      tick();
      i_rd = 1'b0;
      tick();

      // Illegal write to ROM
      i_addr = 13'd5; i_wr = 1'b1; i_datactl_ena = 1'b1; i_wdata = 8'hFF;
      tick();
      i_wr = 1'b0; i_datactl_ena = 1'b0;
      check("rom_wr_err", 32'(o_err), 32'b010);
      tick();
      i_rd = 1'b1; exp_q.push_back(8'h3C);
      tick();
      i_rd = 1'b0;
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      check("err_clr", 32'(o_err), 0);

      // RAM write without datactl_ena: flagged, nothing stored
      i_addr = 13'h1810; i_wr = 1'b1; i_wdata = 8'h66;
      tick();
      i_wr = 1'b0;
      check("noena_err", 32'(o_err), 32'b010);
      tick();
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;

      // rd & wr collision: flagged, no write, no output
      i_addr = 13'h1810; i_rd = 1'b1; i_wr = 1'b1; i_datactl_ena = 1'b1; i_wdata = 8'h99;
      tick();
      check("coll_err", 32'(o_err), 32'b001);
      check("coll_oe",  32'(o_rdata_oe), 0);
      i_rd = 1'b0; i_wr = 1'b0; i_datactl_ena = 1'b0;
      tick();
      i_rd = 1'b1; exp_q.push_back(8'hA5);
      tick();
      i_rd = 1'b0;
      tick();

      // New error wins over a same-edge clear
      i_rd = 1'b1; i_wr = 1'b1; i_err_clr = 1'b1;
      tick();
      i_rd = 1'b0; i_wr = 1'b0; i_err_clr = 1'b0;
      check("clr_vs_new", 32'(o_err), 32'b001);
      tick();

      // Unmapped read
      i_addr = 13'h1000; i_rd = 1'b1; exp_q.push_back(8'h00);
      tick();
      i_rd = 1'b0;
      check("unmapped_rdata", 32'(o_rdata), 0);
      check("unmapped_err2",  32'(o_err[2]), 1);
      tick();

      // Preload on the same edge as a read returns the old word
      i_addr = 13'd5; i_rd = 1'b1; exp_q.push_back(8'h3C);
      i_prog_we = 1'b1; i_prog_addr = 13'd5; i_prog_data = 8'h5A;
      tick();
      i_prog_we = 1'b0;
      exp_q.push_back(8'h5A);
      tick();

      // Reset while in RD drops the output enable on that edge
      rst = 1'b1;
      tick();
      check("rst_in_rd_oe",    32'(o_rdata_oe), 0);
      check("rst_in_rd_rdata", 32'(o_rdata), 0);
      check("rst_in_rd_err",   32'(o_err), 0);
      rst = 1'b0; i_rd = 1'b0;
      tick(); tick();

      check("sb_drained", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
